// File: rtl/muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide sequencer.
// Nine op codes (NONE plus eight HI/LO ops) need a 4-bit encoding.
package muldiv_pkg;

  localparam int XLEN  = 32;
  localparam int ITERS = XLEN;
  localparam int CNT_W = $clog2(ITERS);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MFHI  = 4'd7,
    OP_MFLO  = 4'd8
  } muldiv_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } muldiv_state_t;

  localparam logic [5:0] OPC_SPECIAL = 6'h00;
  localparam logic [5:0] FN_MFHI     = 6'h10;
  localparam logic [5:0] FN_MTHI     = 6'h11;
  localparam logic [5:0] FN_MFLO     = 6'h12;
  localparam logic [5:0] FN_MTLO     = 6'h13;
  localparam logic [5:0] FN_MULT     = 6'h18;
  localparam logic [5:0] FN_MULTU    = 6'h19;
  localparam logic [5:0] FN_DIV      = 6'h1A;
  localparam logic [5:0] FN_DIVU     = 6'h1B;

  // Maps a MIPS opcode/funct pair onto the sequencer op; everything else is NONE.
  function automatic muldiv_op_t decode_muldiv(input logic [5:0] opcode, input logic [5:0] funct);
    muldiv_op_t op;
    op = OP_NONE;
    if (opcode == OPC_SPECIAL) begin
      case (funct)
        FN_MFHI:  op = OP_MFHI;
        FN_MTHI:  op = OP_MTHI;
        FN_MFLO:  op = OP_MFLO;
        FN_MTLO:  op = OP_MTLO;
        FN_MULT:  op = OP_MULT;
        FN_MULTU: op = OP_MULTU;
        FN_DIV:   op = OP_DIV;
        FN_DIVU:  op = OP_DIVU;
        default:  op = OP_NONE;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/muldiv_controller_iter_core.sv
// One combinational step of the engine on the {acc, q} pair:
// shift-add for multiply, restoring shift-subtract for divide.
module muldiv_iter_core
  import muldiv_pkg::*;
(
  input  logic            is_div,
  input  logic [XLEN-1:0] acc,
  input  logic [XLEN-1:0] q,
  input  logic [XLEN-1:0] opnd,
  output logic [XLEN-1:0] acc_next,
  output logic [XLEN-1:0] q_next
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;

  always_comb begin
    sum      = {1'b0, acc} + (q[0] ? {1'b0, opnd} : '0);
    shifted  = {acc, q[XLEN-1]};
    diff     = shifted[XLEN-1:0] - opnd;
    acc_next = sum[XLEN:1];
    q_next   = {sum[0], q[XLEN-1:1]};
    if (is_div) begin
      // Partial remainder stays below the divisor, so the difference fits XLEN bits.
      if (shifted >= {1'b0, opnd}) begin
        acc_next = diff;
        q_next   = {q[XLEN-2:0], 1'b1};
      end else begin
        acc_next = shifted[XLEN-1:0];
        q_next   = {q[XLEN-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_controller.sv
// HI/LO owner and iterative mul/div sequencer beside the EX stage;
// stalls the front end while a HI/LO op meets a running engine.
module muldiv_controller
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  input  muldiv_op_t      ex_op,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  output logic            stall,
  output logic            busy,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic [XLEN-1:0] mf_data
);

  muldiv_state_t    state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [XLEN-1:0]  acc_reg, acc_next;
  logic [XLEN-1:0]  q_reg, q_next;
  logic [XLEN-1:0]  opnd_reg, opnd_next;
  logic             is_div_reg, is_div_next;
  logic             neg_res_reg, neg_res_next;
  logic             neg_rem_reg, neg_rem_next;
  logic [XLEN-1:0]  hi_reg, hi_next;
  logic [XLEN-1:0]  lo_reg, lo_next;

  logic [XLEN-1:0]   core_acc, core_q;
  logic              accept;
  logic              is_signed, is_div_op, div_zero, rs_neg, rt_neg;
  logic [2*XLEN-1:0] prod;

  muldiv_iter_core u_core (
    .is_div   (is_div_reg),
    .acc      (acc_reg),
    .q        (q_reg),
    .opnd     (opnd_reg),
    .acc_next (core_acc),
    .q_next   (core_q)
  );

  assign stall  = ex_valid && (ex_op != OP_NONE) && (state_reg == ST_RUN);
  assign accept = ex_valid && !stall;
  assign busy   = (state_reg == ST_RUN);
  assign hi     = hi_reg;
  assign lo     = lo_reg;

  always_comb begin
    mf_data = '0;
    if (accept && ex_op == OP_MFHI) mf_data = hi_reg;
    if (accept && ex_op == OP_MFLO) mf_data = lo_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      acc_reg     <= '0;
      q_reg       <= '0;
      opnd_reg    <= '0;
      is_div_reg  <= 1'b0;
      neg_res_reg <= 1'b0;
      neg_rem_reg <= 1'b0;
      hi_reg      <= '0;
      lo_reg      <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      acc_reg     <= acc_next;
      q_reg       <= q_next;
      opnd_reg    <= opnd_next;
      is_div_reg  <= is_div_next;
      neg_res_reg <= neg_res_next;
      neg_rem_reg <= neg_rem_next;
      hi_reg      <= hi_next;
      lo_reg      <= lo_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    acc_next     = acc_reg;
    q_next       = q_reg;
    opnd_next    = opnd_reg;
    is_div_next  = is_div_reg;
    neg_res_next = neg_res_reg;
    neg_rem_next = neg_rem_reg;
    hi_next      = hi_reg;
    lo_next      = lo_reg;
    is_signed    = (ex_op == OP_MULT) || (ex_op == OP_DIV);
    is_div_op    = (ex_op == OP_DIV) || (ex_op == OP_DIVU);
    div_zero     = is_div_op && (rt_val == '0);
    rs_neg       = is_signed && rs_val[XLEN-1];
    rt_neg       = is_signed && rt_val[XLEN-1];
    prod         = {core_acc, core_q};

    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          case (ex_op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              // Divide-by-zero keeps the raw dividend so it lands in HI untouched.
              acc_next     = '0;
              q_next       = (rs_neg && !div_zero) ? -rs_val : rs_val;
              opnd_next    = rt_neg ? -rt_val : rt_val;
              is_div_next  = is_div_op;
              neg_res_next = (rs_neg ^ rt_neg) && !div_zero;
              neg_rem_next = rs_neg && is_div_op && !div_zero;
              cnt_next     = '0;
              state_next   = ST_RUN;
            end
            OP_MTHI: hi_next = rs_val;
            OP_MTLO: lo_next = rs_val;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        acc_next = core_acc;
        q_next   = core_q;
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == CNT_W'(ITERS - 1)) begin
          cnt_next   = '0;
          state_next = ST_IDLE;
          if (is_div_reg) begin
            lo_next = neg_res_reg ? -core_q : core_q;
            hi_next = neg_rem_reg ? -core_acc : core_acc;
          end else begin
            if (neg_res_reg) prod = -prod;
            hi_next = prod[2*XLEN-1:XLEN];
            lo_next = prod[XLEN-1:0];
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_muldiv_controller.sv
// Scoreboard bench for muldiv_controller: engine results are queued at issue
// and compared when busy falls; MFHI/MFLO and stall lengths are checked inline.
module tb_muldiv_controller;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  muldiv_op_t  ex_op;
  logic [31:0] rs_val, rt_val;
  logic        stall, busy;
  logic [31:0] hi, lo, mf_data;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;
  logic        prev_busy = 1'b0;
  int          busy_cnt = 0;
  int          s;

  muldiv_controller dut (
    .clk      (clk),
    .reset    (reset),
    .ex_valid (ex_valid),
    .ex_op    (ex_op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .stall    (stall),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo),
    .mf_data  (mf_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Reference result {hi, lo} from native 64-bit arithmetic.
  function automatic logic [63:0] model(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, sq, sr;
    logic [63:0] ua, ub, uq, ur, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    p  = '0;
    case (op)
      OP_MULT:  begin sq = sa * sb; p = sq; end
      OP_MULTU: p = ua * ub;
      OP_DIV: begin
        if (b == 32'h0) p = {a, 32'hFFFFFFFF};
        else begin sq = sa / sb; sr = sa % sb; p = {sr[31:0], sq[31:0]}; end
      end
      OP_DIVU: begin
        if (b == 32'h0) p = {a, 32'hFFFFFFFF};
        else begin uq = ua / ub; ur = ua % ub; p = {ur[31:0], uq[31:0]}; end
      end
      default: p = '0;
    endcase
    return p;
  endfunction

  // Presents one op, holds it through any stall, returns one ns after acceptance.
  task automatic issue(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b, output int stalls);
    logic        done;
    logic [63:0] e;
    done = 1'b0;
    stalls = 0;
    ex_valid = 1'b1;
    ex_op = op;
    rs_val = a;
    rt_val = b;
    while (!done) begin
      @(negedge clk);
      if (!stall) begin
        if (op == OP_MFHI) check("mfhi_data", {32'h0, mf_data}, {32'h0, model_hi});
        if (op == OP_MFLO) check("mflo_data", {32'h0, mf_data}, {32'h0, model_lo});
        done = 1'b1;
      end else begin
        stalls++;
        if (stalls > 100) begin
          check("stall_timeout", 64'(stalls), 64'd0);
          done = 1'b1;
        end
      end
      @(posedge clk);
    end
    #1;
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
        e = model(op, a, b);
        exp_q.push_back(e);
        model_hi = e[63:32];
        model_lo = e[31:0];
      end
      OP_MTHI: model_hi = a;
      OP_MTLO: model_lo = a;
      default: ;
    endcase
    ex_valid = 1'b0;
    ex_op = OP_NONE;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Completion monitor: pops the scoreboard when the engine drops busy.
  always @(negedge clk) begin
    if (reset) begin
      prev_busy <= 1'b0;
      busy_cnt  <= 0;
    end else begin
      if (busy) busy_cnt <= busy_cnt + 1;
      if (prev_busy && !busy) begin
        if (exp_q.size() == 0) check("sb_underflow", 64'd1, 64'd0);
        else begin
          check("res_hi", {32'h0, hi}, {32'h0, exp_q[0][63:32]});
          check("res_lo", {32'h0, lo}, {32'h0, exp_q[0][31:0]});
          check("busy_len", 64'(busy_cnt), 64'd32);
          void'(exp_q.pop_front());
        end
        busy_cnt <= 0;
      end
      prev_busy <= busy;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    ex_valid = 1'b1;
    ex_op = OP_MFHI;
    rs_val = '0;
    rt_val = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_hi", {32'h0, hi}, 64'd0);
    check("rst_lo", {32'h0, lo}, 64'd0);
    check("rst_mf", {32'h0, mf_data}, 64'd0);
    ex_valid = 1'b0;
    ex_op = OP_NONE;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // MULTU max x max, then MFLO stalls for the whole run and reads the new LO
    issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, s);
    issue(OP_MFLO, 32'h0, 32'h0, s);
    check("mflo_stall_len", 64'(s), 64'd32);
    wait_idle();

    issue(OP_MULT, 32'hFFFFFFFD, 32'd7, s);
    wait_idle();
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2, s);
    issue(OP_DIVU, 32'd7, 32'd2, s);
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, s);
    issue(OP_DIVU, 32'd5, 32'd0, s);
    issue(OP_DIV, 32'hFFFFFFF6, 32'd0, s);
    issue(OP_DIV, 32'd7, 32'hFFFFFFFE, s);
    wait_idle();

    // MTHI/MFHI back to back: no stall, forwarded value visible
    issue(OP_MTHI, 32'h12345678, 32'h0, s);
    check("mthi_stall", 64'(s), 64'd0);
    issue(OP_MFHI, 32'h0, 32'h0, s);
    check("mfhi_stall", 64'(s), 64'd0);

    // MTLO during RUN waits, then overwrites the product's LO
    issue(OP_MULTU, 32'd3, 32'd5, s);
    issue(OP_MTLO, 32'd9, 32'h0, s);
    check("mtlo_stall_len", 64'(s), 64'd32);
    check("mtlo_lo", {32'h0, lo}, 64'd9);
    issue(OP_MFLO, 32'h0, 32'h0, s);

    // Reset in the middle of a run aborts without writing HI/LO
    issue(OP_MULTU, 32'd100, 32'd200, s);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    ex_valid = 1'b1;
    ex_op = OP_MFLO;
    @(posedge clk);
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_stall", 64'(stall), 64'd0);
    check("abort_hi", {32'h0, hi}, 64'd0);
    check("abort_lo", {32'h0, lo}, 64'd0);
    ex_valid = 1'b0;
    ex_op = OP_NONE;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    model_hi = '0;
    model_lo = '0;
    issue(OP_MULTU, 32'd2, 32'd3, s);
    wait_idle();

    for (int i = 0; i < 6; i++) begin
      issue(muldiv_op_t'(4'($urandom_range(1, 4))), $urandom(), $urandom(), s);
      wait_idle();
    end
    issue(OP_MFHI, 32'h0, 32'h0, s);

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
